sr_latch_monitor: RTL and testbench
===================================

SR_LATCH_MONITOR -- requirements
Module: sr_latch_monitor

Interface
REQ-001 Parameter SETTLE_CYC, default 4: clock cycles allowed for latch outputs to settle after a command change (legal range 1..15).
REQ-002 Parameter CNT_W, default 8: width of the error counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 s  input  1  set command driven into the latch under observation.
REQ-006 r  input  1  reset command driven into the latch under observation.
REQ-007 q  input  1  latch true output.
REQ-008 qb  input  1  latch complement output.
REQ-009 exp_q  output  1  expected latch state.
REQ-010 known  output  1  high while the FSM is in KNOWN.
REQ-011 err  output  1  one-cycle pulse when a check fails.
REQ-012 forbid  output  1  one-cycle pulse on entry to FORBID.
REQ-013 err_cnt  output  CNT_W  count of err pulses.

Function
REQ-014 The block SHALL register s, r, q and qb in one input stage; all decisions SHALL use the registered values (sS, sR, sQ, sQB).
REQ-015 Command decode from {sS,sR} SHALL be: 00 HOLD, 10 SET, 01 CLR, 11 ILLEGAL.
REQ-016 The FSM SHALL have states UNKNOWN, SETTLING, KNOWN, FORBID, plus a settle counter loaded with SETTLE_CYC.
REQ-017 UNKNOWN: HOLD -> stay; SET/CLR -> SETTLING, exp_q=1/0, counter loaded; ILLEGAL -> FORBID, counter loaded; no output checks.
REQ-018 SETTLING: the counter SHALL decrement each cycle and the FSM SHALL move to KNOWN on the cycle it reaches 0.
REQ-019 SETTLING: a SET/CLR that changes exp_q SHALL update exp_q and reload the counter; the same command or HOLD SHALL not reload; ILLEGAL -> FORBID with reload.
REQ-020 KNOWN: every cycle, err SHALL pulse if sQ != exp_q or sQB != ~exp_q, evaluated against the current state before any transition in that cycle.
REQ-021 KNOWN: HOLD or the same command -> stay; the opposite command -> SETTLING with exp_q updated and reload; ILLEGAL -> FORBID with reload.
REQ-022 FORBID: the counter SHALL decrement to 0 and hold there; once at 0, err SHALL pulse each cycle in which sQ or sQB is 1 (NOR-latch both-low rule).
REQ-023 FORBID exit: HOLD -> UNKNOWN; SET/CLR -> SETTLING with exp_q updated and reload; ILLEGAL -> stay.
REQ-024 forbid SHALL pulse only on the transition into FORBID, not while remaining there.
REQ-025 err_cnt SHALL increment by 1 on each err pulse and SHALL saturate at 2^CNT_W-1.
REQ-026 Latency: a value on s, r, q or qb SHALL affect state and outputs 2 rising edges after it is presented.
REQ-027 exp_q SHALL hold its last value in UNKNOWN and FORBID.

Reset
REQ-028 With rst high at a rising edge, the block SHALL force state=UNKNOWN, counter=0, exp_q=0, known=0, err=0, forbid=0, err_cnt=0 and clear the input stage.
REQ-029 Reset asserted mid-SETTLING or mid-FORBID SHALL abandon the operation with no err or forbid pulse.
REQ-030 rst SHALL take priority over every other event in the same cycle.

Verification (SETTLE_CYC=4)
REQ-031 Reset, then s/r=10 for one cycle, then 00, with q=1 and qb=0 from edge 2 onward -> known rises 4 cycles after SETTLING entry, exp_q=1, err never pulses, err_cnt=0.
REQ-032 In KNOWN with exp_q=1, force q=0 for 3 cycles -> err pulses on 3 consecutive cycles and err_cnt=3.
REQ-033 s/r=11 from KNOWN with q=qb=1 held -> forbid pulses once, no err for 4 cycles, then err every cycle until q=qb=0.
REQ-034 Sequence 01, 00, 10, 00, 11, 00 with a correct latch model -> states UNKNOWN->SETTLING->KNOWN->SETTLING->KNOWN->FORBID->UNKNOWN, err_cnt=0, one forbid pulse.
REQ-035 With CNT_W=2, drive 5 mismatches in KNOWN -> err_cnt saturates at 3.
REQ-036 rst asserted 2 cycles into SETTLING -> next cycle all outputs are 0, state is UNKNOWN, and no err is produced.

Source files
------------

// File: rtl/sr_latch_monitor.sv
// Monitor for an external SR latch. Registers the latch command and
// outputs once, tracks the state the latch should be in, and flags outputs
// that disagree with it once the settle window has elapsed.
module sr_latch_monitor #(
  parameter int unsigned SETTLE_CYC = 4,  // settle window in cycles, 1..15
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  input  logic             r,
  input  logic             q,
  input  logic             qb,
  output logic             exp_q,
  output logic             known,
  output logic             err,
  output logic             forbid,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {UNKNOWN, SETTLING, KNOWN, FORBID} state_e;
  // Command encoding is {s, r}.
  typedef enum logic [1:0] {HOLD = 2'b00, CLR = 2'b01, SET = 2'b10, ILL = 2'b11} cmd_e;

  localparam logic [3:0]       RELOAD  = 4'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             s_q, r_q, q_q, qb_q;
  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             expq_q, expq_d;
  logic             known_q, err_q, forbid_q;
  logic             err_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  cmd_e             cmd;
  logic             drive;

  assign cmd   = cmd_e'({s_q, r_q});
  assign drive = (cmd == SET) || (cmd == CLR);

  // Input stage: every decision below uses these registered samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q  <= 1'b0;
      r_q  <= 1'b0;
      q_q  <= 1'b0;
      qb_q <= 1'b0;
    end else begin
      s_q  <= s;
      r_q  <= r;
      q_q  <= q;
      qb_q <= qb;
    end
  end

  // Next state, settle counter, expected value and check result.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    expq_d  = expq_q;
    err_d   = 1'b0;
    unique case (state_q)
      UNKNOWN: begin
        if (drive) begin
          state_d = SETTLING;
          expq_d  = s_q;
          cnt_d   = RELOAD;
        end else if (cmd == ILL) begin
          state_d = FORBID;
          cnt_d   = RELOAD;
        end
      end
      SETTLING: begin
        if (cmd == ILL) begin
          state_d = FORBID;
          cnt_d   = RELOAD;
        end else if (drive && (s_q != expq_q)) begin
          // A reversed command restarts the settle window.
          expq_d = s_q;
          cnt_d  = RELOAD;
        end else begin
          cnt_d = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = KNOWN;
        end
      end
      KNOWN: begin
        // Checked against the expectation held before any transition.
        err_d = (q_q != expq_q) || (qb_q != ~expq_q);
        if (cmd == ILL) begin
          state_d = FORBID;
          cnt_d   = RELOAD;
        end else if (drive && (s_q != expq_q)) begin
          state_d = SETTLING;
          expq_d  = s_q;
          cnt_d   = RELOAD;
        end
      end
      FORBID: begin
        // A NOR latch with both inputs high drives both outputs low.
        if (cnt_q == 4'd0) err_d = q_q || qb_q;
        else               cnt_d = cnt_q - 4'd1;
        if (cmd == HOLD) begin
          state_d = UNKNOWN;
        end else if (drive) begin
          state_d = SETTLING;
          expq_d  = s_q;
          cnt_d   = RELOAD;
        end
      end
      default: state_d = UNKNOWN;
    endcase
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + CNT_ONE;
  end

  // FSM state and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= UNKNOWN;
      cnt_q     <= 4'd0;
      expq_q    <= 1'b0;
      known_q   <= 1'b0;
      err_q     <= 1'b0;
      forbid_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      expq_q    <= expq_d;
      known_q   <= (state_d == KNOWN);
      err_q     <= err_d;
      forbid_q  <= (state_d == FORBID) && (state_q != FORBID);
      err_cnt_q <= err_cnt_d;
    end
  end

  assign exp_q   = expq_q;
  assign known   = known_q;
  assign err     = err_q;
  assign forbid  = forbid_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_sr_latch_monitor.sv
// Bench for sr_latch_monitor: directed vector table, hand sequences for
// the multi-cycle cases, then random traffic against a timestamp model.
module tb_sr_latch_monitor;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1, s = 1'b0, r = 1'b0, q = 1'b0, qb = 1'b0;
  logic       exp_q, known, err, forbid;
  logic [7:0] err_cnt;
  logic       exp_q2, known2, err2, forbid2;
  logic [1:0] err_cnt2;

  sr_latch_monitor #(.SETTLE_CYC(S), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(q), .qb(qb),
    .exp_q(exp_q), .known(known), .err(err), .forbid(forbid), .err_cnt(err_cnt));

  sr_latch_monitor #(.SETTLE_CYC(S), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .s(s), .r(r), .q(q), .qb(qb),
    .exp_q(exp_q2), .known(known2), .err(err2), .forbid(forbid2), .err_cnt(err_cnt2));

  always #5 clk = ~clk;

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input int act, input int req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Reference model: the monitor's view of the world is the input sample
  // from the previous edge; settle windows are absolute edge deadlines.
  int m_t = 0, m_mode = 0, m_dl = 0, m_cnt = 0;  // mode 0 unk 1 settle 2 known 3 forbid
  bit m_exp, m_known, m_err, m_forbid;
  bit st_s, st_r, st_q, st_qb;

  function automatic void model_edge(bit rv, bit sv, bit rr, bit qv, bit qbv);
    int prev;
    bit drv, ill;
    m_t++;
    if (rv) begin
      m_mode = 0; m_exp = 0; m_dl = 0; m_cnt = 0;
      m_known = 0; m_err = 0; m_forbid = 0;
      {st_s, st_r, st_q, st_qb} = 4'b0000;
      return;
    end
    prev = m_mode;
    drv  = st_s ^ st_r;
    ill  = st_s & st_r;
    m_err = 0;
    case (m_mode)
      0: if (drv) begin m_mode = 1; m_exp = st_s; m_dl = m_t + S; end
         else if (ill) begin m_mode = 3; m_dl = m_t + S; end
      1: if (ill) begin m_mode = 3; m_dl = m_t + S; end
         else if (drv && st_s != m_exp) begin m_exp = st_s; m_dl = m_t + S; end
         else if (m_t >= m_dl) m_mode = 2;
      2: begin
        m_err = (st_q != m_exp) || (st_qb == m_exp);
        if (ill) begin m_mode = 3; m_dl = m_t + S; end
        else if (drv && st_s != m_exp) begin m_mode = 1; m_exp = st_s; m_dl = m_t + S; end
      end
      default: begin
        m_err = (m_t > m_dl) && (st_q || st_qb);
        if (!st_s && !st_r) m_mode = 0;
        else if (drv) begin m_mode = 1; m_exp = st_s; m_dl = m_t + S; end
      end
    endcase
    m_known  = (m_mode == 2);
    m_forbid = (m_mode == 3) && (prev != 3);
    if (m_err && m_cnt < 255) m_cnt++;
    {st_s, st_r, st_q, st_qb} = {sv, rr, qv, qbv};
  endfunction

  task automatic cyc(input bit rv, input bit sv, input bit rr, input bit qv, input bit qbv);
    rst = rv; s = sv; r = rr; q = qv; qb = qbv;
    @(posedge clk);
    model_edge(rv, sv, rr, qv, qbv);
    #1;
    chk($sformatf("t%0d exp_q", m_t), int'(exp_q), int'(m_exp));
    chk($sformatf("t%0d known", m_t), int'(known), int'(m_known));
    chk($sformatf("t%0d err", m_t), int'(err), int'(m_err));
    chk($sformatf("t%0d forbid", m_t), int'(forbid), int'(m_forbid));
    chk($sformatf("t%0d err_cnt", m_t), int'(err_cnt), m_cnt);
    chk($sformatf("t%0d err_cnt_w2", m_t), int'(err_cnt2), (m_cnt > 3) ? 3 : m_cnt);
  endtask

  // Behavioural NOR latch whose outputs follow the command one cycle later.
  bit lq = 0, lqb = 1;
  task automatic lcyc(input bit rv, input bit sv, input bit rr, input bit corrupt);
    cyc(rv, sv, rr, lq ^ corrupt, lqb);
    if (rv) begin lq = 0; lqb = 1; end
    else if (sv && rr) begin lq = 0; lqb = 0; end
    else if (sv) begin lq = 1; lqb = 0; end
    else if (rr) begin lq = 0; lqb = 1; end
  endtask

  typedef struct {
    bit [4:0] in;   // {rst, s, r, q, qb}
    bit [3:0] out;  // {exp_q, known, err, forbid}
    int       cnt;
  } vec_t;

  function automatic vec_t v(bit [4:0] in, bit [3:0] out, int cnt);
    vec_t x;
    x.in = in; x.out = out; x.cnt = cnt;
    return x;
  endfunction

  initial begin
    vec_t tbl[21];
    int fcnt, krise, errs;
    bit pk, rs, sv, rr, cor;
    int p;

    // Settle to KNOWN, 3-cycle q fault, then forbidden command with q=qb=1.
    tbl[0]  = v(5'b10001, 4'b0000, 0);
    tbl[1]  = v(5'b01001, 4'b0000, 0);
    tbl[2]  = v(5'b00010, 4'b1000, 0);
    tbl[3]  = v(5'b00010, 4'b1000, 0);
    tbl[4]  = v(5'b00010, 4'b1000, 0);
    tbl[5]  = v(5'b00010, 4'b1000, 0);
    tbl[6]  = v(5'b00010, 4'b1100, 0);
    tbl[7]  = v(5'b00000, 4'b1100, 0);
    tbl[8]  = v(5'b00000, 4'b1110, 1);
    tbl[9]  = v(5'b00000, 4'b1110, 2);
    tbl[10] = v(5'b00010, 4'b1110, 3);
    tbl[11] = v(5'b00010, 4'b1100, 3);
    tbl[12] = v(5'b01110, 4'b1100, 3);
    tbl[13] = v(5'b01111, 4'b1001, 3);
    tbl[14] = v(5'b01111, 4'b1000, 3);
    tbl[15] = v(5'b01111, 4'b1000, 3);
    tbl[16] = v(5'b01111, 4'b1000, 3);
    tbl[17] = v(5'b01111, 4'b1000, 3);
    tbl[18] = v(5'b01111, 4'b1010, 4);
    tbl[19] = v(5'b01100, 4'b1010, 5);
    tbl[20] = v(5'b01100, 4'b1000, 5);

    for (int i = 0; i < 21; i++) begin
      {rst, s, r, q, qb} = tbl[i].in;
      @(posedge clk);
      model_edge(tbl[i].in[4], tbl[i].in[3], tbl[i].in[2], tbl[i].in[1], tbl[i].in[0]);
      #1;
      chk($sformatf("row%0d exp_q", i), int'(exp_q), int'(tbl[i].out[3]));
      chk($sformatf("row%0d known", i), int'(known), int'(tbl[i].out[2]));
      chk($sformatf("row%0d err", i), int'(err), int'(tbl[i].out[1]));
      chk($sformatf("row%0d forbid", i), int'(forbid), int'(tbl[i].out[0]));
      chk($sformatf("row%0d err_cnt", i), int'(err_cnt), tbl[i].cnt);
      chk($sformatf("row%0d err_cnt_w2", i), int'(err_cnt2), (tbl[i].cnt > 3) ? 3 : tbl[i].cnt);
    end

    // CLR, SET, ILLEGAL round trip with a well-behaved latch.
    lcyc(1, 0, 0, 0);
    fcnt = 0; krise = 0; pk = known;
    for (int k = 0; k < 17; k++) begin
      case (k)
        0:       lcyc(0, 0, 1, 0);
        6:       lcyc(0, 1, 0, 0);
        12:      lcyc(0, 1, 1, 0);
        default: lcyc(0, 0, 0, 0);
      endcase
      if (forbid) fcnt++;
      if (known && !pk) krise++;
      pk = known;
    end
    chk("seq_forbid_pulses", fcnt, 1);
    chk("seq_known_rises", krise, 2);
    chk("seq_err_cnt", int'(err_cnt), 0);
    chk("seq_end_known", int'(known), 0);

    // Five mismatches in KNOWN: narrow counter saturates.
    lcyc(1, 0, 0, 0);
    lcyc(0, 1, 0, 0);
    repeat (6) lcyc(0, 0, 0, 0);
    repeat (5) lcyc(0, 0, 0, 1);
    repeat (2) lcyc(0, 0, 0, 0);
    chk("sat_err_cnt_w8", int'(err_cnt), 5);
    chk("sat_err_cnt_w2", int'(err_cnt2), 3);

    // Reset two cycles into SETTLING abandons it silently.
    lcyc(1, 0, 0, 0);
    lcyc(0, 1, 0, 0);
    repeat (3) lcyc(0, 0, 0, 0);
    lcyc(1, 0, 0, 0);
    chk("rst_mid exp_q", int'(exp_q), 0);
    chk("rst_mid known", int'(known), 0);
    chk("rst_mid err", int'(err), 0);
    chk("rst_mid forbid", int'(forbid), 0);
    chk("rst_mid err_cnt", int'(err_cnt), 0);
    errs = 0;
    repeat (8) begin
      lcyc(0, 0, 0, 0);
      if (err || known) errs++;
    end
    chk("rst_mid quiet", errs, 0);

    // Random commands, occasional output faults and resets.
    lcyc(1, 0, 0, 0);
    repeat (800) begin
      rs  = ($urandom_range(0, 63) == 0);
      p   = $urandom_range(0, 15);
      sv  = (p == 10 || p == 11 || p == 14);
      rr  = (p == 12 || p == 13 || p == 14);
      cor = ($urandom_range(0, 9) == 0);
      lcyc(rs, sv, rr, cor);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
